// File: rtl/sram_1rw_arb2_pkg.sv
// Shared types and defaults for the two-requester 1RW SRAM arbiter.
// Optional init sweep is enabled by defining SRAM_ARB_INIT_EN.
package sram_1rw_arb2_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 128;
    localparam int unsigned DEF_ADDR_WIDTH = 11;

    // Top-level FSM: INIT only exists when the zero-fill sweep is compiled in
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    // Requester index, also used as the round-robin pointer value
    typedef logic req_idx_t;

    localparam req_idx_t REQ_P0 = 1'b0;
    localparam req_idx_t REQ_P1 = 1'b1;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant with a registered priority pointer.
module sram_rr_arb2
    import sram_1rw_arb2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant_c,
    output req_idx_t   grant_idx_c
);

    req_idx_t ptr;

    // Grant a lone requester outright; on contention the pointer decides
    always_comb begin
        grant_c     = 2'b00;
        grant_idx_c = REQ_P0;
        if (enable) begin
            case (valid)
                2'b01: begin
                    grant_c     = 2'b01;
                    grant_idx_c = REQ_P0;
                end
                2'b10: begin
                    grant_c     = 2'b10;
                    grant_idx_c = REQ_P1;
                end
                2'b11: begin
                    if (ptr == REQ_P1) begin
                        grant_c     = 2'b10;
                        grant_idx_c = REQ_P1;
                    end else begin
                        grant_c     = 2'b01;
                        grant_idx_c = REQ_P0;
                    end
                end
                default: begin
                    grant_c     = 2'b00;
                    grant_idx_c = REQ_P0;
                end
            endcase
        end
    end

    // After any grant the loser (or the idle side) gets priority next time
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_P0;
        end else if (|grant_c) begin
            ptr <= req_idx_t'(~grant_idx_c);
        end
    end

endmodule

// File: rtl/sram_1rw_arb2.sv
// Two-requester front end for a single-port (1RW) SRAM macro.
// Define SRAM_ARB_INIT_EN to zero-fill the macro after every reset.
module sram_1rw_arb2
    import sram_1rw_arb2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,

    output logic                  init_done
);

    arb_state_t            state;
    logic                  accept_en_c;
    logic [1:0]            grant_c;
    req_idx_t              grant_idx_c;
    logic                  xfer_c;
    logic                  sel_we_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;
    logic                  web_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rsp_pend;
    req_idx_t              rsp_owner;

`ifdef SRAM_ARB_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_wr_c;

    assign init_wr_c = (state == ST_INIT) && !rst0;
`endif

    // Requests are only taken in RUN, after init_done, and never in a reset cycle
    assign accept_en_c = (state == ST_RUN) && init_done && !rst0;

    sram_rr_arb2 u_arb (
        .clk         (clk0),
        .rst         (rst0),
        .enable      (accept_en_c),
        .valid       ({p1_req_valid, p0_req_valid}),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign p0_req_ready = grant_c[0];
    assign p1_req_ready = grant_c[1];
    assign xfer_c       = |grant_c;

    // Select the granted requester's command
    always_comb begin
        sel_we_c    = p0_req_we;
        sel_addr_c  = p0_req_addr;
        sel_wdata_c = p0_req_wdata;
        if (grant_idx_c == REQ_P1) begin
            sel_we_c    = p1_req_we;
            sel_addr_c  = p1_req_addr;
            sel_wdata_c = p1_req_wdata;
        end
    end

    // Macro pins: drive the init sweep or the granted request, else hold last values
    always_comb begin
        csb0  = 1'b1;
        web0  = web_q;
        addr0 = addr_q;
        din0  = din_q;
`ifdef SRAM_ARB_INIT_EN
        if (init_wr_c) begin
            csb0  = 1'b0;
            web0  = 1'b0;
            addr0 = init_cnt;
            din0  = '0;
        end else
`endif
        if (xfer_c) begin
            csb0  = 1'b0;
            web0  = !sel_we_c;
            addr0 = sel_addr_c;
            din0  = sel_wdata_c;
        end
    end

    // Remember the last driven pin values so idle cycles do not toggle the macro
    always_ff @(posedge clk0) begin
        if (rst0) begin
            web_q  <= 1'b1;
            addr_q <= '0;
            din_q  <= '0;
        end else if (!csb0) begin
            web_q  <= web0;
            addr_q <= addr0;
            din_q  <= din0;
        end
    end

    // Control FSM: optional zero-fill sweep, then RUN with init_done set
    always_ff @(posedge clk0) begin
        if (rst0) begin
`ifdef SRAM_ARB_INIT_EN
            state    <= ST_INIT;
            init_cnt <= '0;
`else
            state    <= ST_RUN;
`endif
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
`ifdef SRAM_ARB_INIT_EN
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
`else
                    state <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // Track the one outstanding read and which requester owns it
    always_ff @(posedge clk0) begin
        if (rst0) begin
            rsp_pend  <= 1'b0;
            rsp_owner <= REQ_P0;
        end else begin
            rsp_pend <= xfer_c && !sel_we_c;
            if (xfer_c) begin
                rsp_owner <= grant_idx_c;
            end
        end
    end

    // A reset cycle suppresses any response still in flight
    assign p0_rsp_valid = rsp_pend && (rsp_owner == REQ_P0) && !rst0;
    assign p1_rsp_valid = rsp_pend && (rsp_owner == REQ_P1) && !rst0;
    assign p0_rsp_rdata = dout0;
    assign p1_rsp_rdata = dout0;

endmodule

// File: tb/tb_sram_1rw_arb2.sv
// Scoreboard bench for sram_1rw_arb2 with a behavioural 1RW macro.
// Build with SRAM_ARB_INIT_EN defined to exercise the zero-fill sweep.
module tb_sram_1rw_arb2;

    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          p0_req_valid, p0_req_ready, p0_req_we;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_rsp_valid;
    logic [DW-1:0] p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_we;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata;
    logic          p1_rsp_valid;
    logic [DW-1:0] p1_rsp_rdata;
    logic          csb0, web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          init_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Scoreboard / model state
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            grant_log[$];
    bit            mon_on = 1'b0;
    bit            log_on = 1'b0;
    bit            ptr_m, pend0, pend1, eg0, eg1;
    logic          last_web;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_din;
    logic [DW-1:0] exp_d;

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    sram_1rw_arb2 #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk0         (clk0),
        .rst0         (rst0),
        .p0_req_valid (p0_req_valid),
        .p0_req_ready (p0_req_ready),
        .p0_req_we    (p0_req_we),
        .p0_req_addr  (p0_req_addr),
        .p0_req_wdata (p0_req_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_req_we    (p1_req_we),
        .p1_req_addr  (p1_req_addr),
        .p1_req_wdata (p1_req_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_rdata (p1_rsp_rdata),
        .csb0         (csb0),
        .web0         (web0),
        .addr0        (addr0),
        .din0         (din0),
        .dout0        (dout0),
        .init_done    (init_done)
    );

    // Behavioural 1RW macro, one-cycle read latency
    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) mem[addr0] <= din0;
            else       dout0 <= mem[addr0];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle-level reference: arbitration, pin values and response routing
    always @(negedge clk0) begin
        if (mon_on) begin
            eg0 = p0_req_valid && !rst0 && (!p1_req_valid || !ptr_m);
            eg1 = p1_req_valid && !rst0 && (!p0_req_valid || ptr_m);
            chk("p0_ready", DW'(p0_req_ready), DW'(eg0));
            chk("p1_ready", DW'(p1_req_ready), DW'(eg1));
            chk("csb0", DW'(csb0), DW'(!(eg0 || eg1)));
            if (eg0) begin
                last_web = !p0_req_we; last_addr = p0_req_addr; last_din = p0_req_wdata;
            end else if (eg1) begin
                last_web = !p1_req_we; last_addr = p1_req_addr; last_din = p1_req_wdata;
            end
            chk("web0", DW'(web0), DW'(last_web));
            chk("addr0", DW'(addr0), DW'(last_addr));
            chk("din0", din0, last_din);
            chk("p0_rsp_valid", DW'(p0_rsp_valid), DW'(pend0 && !rst0));
            chk("p1_rsp_valid", DW'(p1_rsp_valid), DW'(pend1 && !rst0));
            if (pend0 && !rst0 && q0.size() > 0) begin
                exp_d = q0.pop_front();
                chk("p0_rdata", p0_rsp_rdata, exp_d);
            end
            if (pend1 && !rst0 && q1.size() > 0) begin
                exp_d = q1.pop_front();
                chk("p1_rdata", p1_rsp_rdata, exp_d);
            end
            if (rst0) begin
                pend0 = 1'b0; pend1 = 1'b0; ptr_m = 1'b0;
                last_web = 1'b1; last_addr = '0; last_din = '0;
                q0.delete(); q1.delete();
            end else begin
                pend0 = eg0 && !p0_req_we;
                pend1 = eg1 && !p1_req_we;
                if (eg0) begin
                    if (p0_req_we) ref_mem[p0_req_addr] = p0_req_wdata;
                    else           q0.push_back(ref_mem[p0_req_addr]);
                    ptr_m = 1'b1;
                    if (log_on) grant_log.push_back(0);
                end
                if (eg1) begin
                    if (p1_req_we) ref_mem[p1_req_addr] = p1_req_wdata;
                    else           q1.push_back(ref_mem[p1_req_addr]);
                    ptr_m = 1'b0;
                    if (log_on) grant_log.push_back(1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        if (p == 0) begin
            p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
        end else begin
            p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk0);
            if ((p == 0 && p0_req_ready) || (p == 1 && p1_req_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_accept", DW'(ok), DW'(1));
        step();
        if (p == 0) p0_req_valid = 1'b0;
        else        p1_req_valid = 1'b0;
    endtask

    task automatic mon_seed();
        ptr_m = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
`ifdef SRAM_ARB_INIT_EN
        last_web = 1'b0; last_addr = '1; last_din = '0;
`else
        last_web = 1'b1; last_addr = '0; last_din = '0;
`endif
        mon_on = 1'b1;
    endtask

    // Called right after reset release; ends aligned #1 after a rising edge
    task automatic wait_init(input string tag);
`ifdef SRAM_ARB_INIT_EN
        int n;
        bit seq_ok;
        bit done;
        n = 0; seq_ok = 1'b1; done = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk0);
            if (init_done) begin
                done = 1'b1;
                break;
            end
            if (!csb0 && !web0 && din0 == '0 && addr0 == AW'(n)) n++;
            else seq_ok = 1'b0;
        end
        chk({tag, "_done"}, DW'(done), DW'(1));
        chk({tag, "_write_count"}, DW'(n), DW'(DEPTH));
        chk({tag, "_write_seq"}, DW'(seq_ok), DW'(1));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
        @(negedge clk0);
        chk({tag, "_done_before_edge"}, DW'(init_done), DW'(0));
        step();
        chk({tag, "_done"}, DW'(init_done), DW'(1));
`endif
        step();
        mon_seed();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst0 = 1'b1;
        p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0;
        p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk0);
        @(negedge clk0);
        chk("rst_csb0", DW'(csb0), DW'(1));
        chk("rst_web0", DW'(web0), DW'(1));
        chk("rst_addr0", DW'(addr0), DW'(0));
        chk("rst_din0", din0, DW'(0));
        chk("rst_p0_ready", DW'(p0_req_ready), DW'(0));
        chk("rst_p1_ready", DW'(p1_req_ready), DW'(0));
        chk("rst_init_done", DW'(init_done), DW'(0));
        chk("rst_p0_rsp_valid", DW'(p0_rsp_valid), DW'(0));
        chk("rst_p1_rsp_valid", DW'(p1_rsp_valid), DW'(0));
        step();
        rst0 = 1'b0;
        wait_init("init");

`ifdef SRAM_ARB_INIT_EN
        // Top address reads back as zero after the sweep
        req(0, 1'b0, '1, '0);
`endif

        // Write then read-after-write on p0
        req(0, 1'b1, AW'(32'h010), {16{8'hA5}});
        req(0, 1'b0, AW'(32'h010), '0);
        @(negedge clk0);
        chk("raw_p0_rsp_valid", DW'(p0_rsp_valid), DW'(1));
        chk("raw_p0_rdata", p0_rsp_rdata, {16{8'hA5}});
        chk("raw_p1_rsp_valid", DW'(p1_rsp_valid), DW'(0));
        step();

        // A p1 grant leaves the pointer on p0
        req(1, 1'b1, AW'(32'h020), {4{32'h5A5A_0123}});

        // Both requesters saturating: grants must alternate starting with p0
        grant_log.delete();
        log_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) req(0, 1'b0, AW'(32'h010), '0);
            end
            begin
                for (int i = 0; i < 3; i++) req(1, 1'b0, AW'(32'h020), '0);
            end
        join
        log_on = 1'b0;
        chk("alt_grant_count", DW'(grant_log.size()), DW'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("alt_grant_order", DW'(grant_log[i]), DW'(i % 2));
        end
        step();

        // Lone p1 streams with no bubbles even though pointer favours p0
        t0 = cyc;
        for (int i = 0; i < 3; i++) req(1, 1'b0, AW'(32'h010), '0);
        chk("p1_streak_cycles", DW'(cyc - t0), DW'(3));

        // Mixed random traffic over a pre-written window
        for (int i = 0; i < 16; i++) req(0, 1'b1, AW'(32'h100 + i), {4{$urandom()}});
        fork
            begin
                for (int i = 0; i < 25; i++)
                    req(0, 1'($urandom_range(0, 1)), AW'(32'h100 + $urandom_range(0, 15)),
                        {$urandom(), $urandom(), $urandom(), $urandom()});
            end
            begin
                for (int i = 0; i < 25; i++)
                    req(1, 1'($urandom_range(0, 1)), AW'(32'h100 + $urandom_range(0, 15)),
                        {$urandom(), $urandom(), $urandom(), $urandom()});
            end
        join
        step();

        // Reset right after a p1 read accept drops the response
        req(1, 1'b0, AW'(32'h020), '0);
        rst0 = 1'b1;
        mon_on = 1'b0;
        @(negedge clk0);
        chk("rstmid_p1_rsp_valid", DW'(p1_rsp_valid), DW'(0));
        chk("rstmid_p0_rsp_valid", DW'(p0_rsp_valid), DW'(0));
        step();
        @(negedge clk0);
        chk("rstmid_p1_rsp_valid_after", DW'(p1_rsp_valid), DW'(0));
        chk("rstmid_init_done", DW'(init_done), DW'(0));
        chk("rstmid_csb0", DW'(csb0), DW'(1));
        step();
        rst0 = 1'b0;
        wait_init("reinit");

        // Normal service resumes after the second reset
        req(0, 1'b1, AW'(32'h033), {8{16'hBEEF}});
        req(1, 1'b0, AW'(32'h033), '0);
        repeat (2) step();

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
